j_u2tx: RTL



---
 rtl/j_uart_pkg.sv | 20 ++
 rtl/j_uart_bitclk.sv | 33 +++
 rtl/j_u2tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/j_uart_pkg.sv
// Shared UART2 definitions: framing defaults, transmitter FSM states, parity helper.
package j_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Zero-extension to 32 bits leaves the XOR reduction unchanged.
    function automatic logic par_bit(input logic [31:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/j_uart_bitclk.sv
// Bit-time divider: counts bx16 ticks and flags the last tick of every bit.
module j_uart_bitclk #(
    parameter int OVERSAMPLE = j_uart_pkg::OVERSAMPLE
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic en,
    input  logic clr,
    output logic bit_end
);

    localparam int            CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = tick & en & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (tick & en)
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/j_u2tx.sv
// UART2 transmitter: holding register feeding a start/data/parity/stop shifter,
// paced by the 16x-baud enable from the prescaler.
module j_u2tx #(
    parameter int DATA_BITS  = j_uart_pkg::DATA_BITS,
    parameter int OVERSAMPLE = j_uart_pkg::OVERSAMPLE
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 bx16,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 u2dataw,
    input  logic                 pen,
    input  logic                 pev,
    input  logic                 txbrk,
    output logic                 txd,
    output logic                 tbe,
    output logic                 tsre,
    output logic                 txint
);

    import j_uart_pkg::*;

    localparam int            IW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] thr_q, thr_d, sh_q, sh_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 thr_full_q, thr_full_d;
    logic                 pen_q, pen_d, par_q, par_d;
    logic                 txd_q, txd_d, txint_q, txint_d;
    logic                 bit_end, xfer, level;

    // Transfer from idle waits for a tick; from STOP it chains at the stop-bit end.
    assign xfer = thr_full_q & (((state_q == ST_IDLE) & bx16) |
                                ((state_q == ST_STOP) & bit_end));

    j_uart_bitclk #(.OVERSAMPLE(OVERSAMPLE)) u_bitclk (
        .clk     (sys_clk),
        .rst     (reset),
        .tick    (bx16),
        .en      (state_q != ST_IDLE),
        .clr     (xfer),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        thr_full_d = thr_full_q;
        sh_d       = sh_q;
        idx_d      = idx_q;
        pen_d      = pen_q;
        par_d      = par_q;
        txint_d    = xfer;
        level      = 1'b1;

        // A write on the transfer cycle wins: shifter gets the old thr, thr stays full.
        if (u2dataw) begin
            thr_d      = din;
            thr_full_d = 1'b1;
        end else if (xfer) begin
            thr_full_d = 1'b0;
        end

        if (xfer) begin
            sh_d    = thr_q;
            pen_d   = pen;
            par_d   = par_bit(32'(thr_q), pev);
            idx_d   = '0;
            state_d = ST_START;
        end else if (bit_end) begin
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
                ST_DATA: begin
                    if (idx_q == LAST_IDX) state_d = pen_q ? ST_PARITY : ST_STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end
                ST_PARITY: state_d = ST_STOP;
                default:   state_d = ST_IDLE;
            endcase
        end

        // txd is registered from the next state so it changes on the same edge as the FSM.
        case (state_d)
            ST_START:  level = 1'b0;
            ST_DATA:   level = sh_d[idx_d];
            ST_PARITY: level = par_d;
            default:   level = 1'b1;
        endcase
        txd_d = level & ~txbrk;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            thr_q      <= '0;
            thr_full_q <= 1'b0;
            sh_q       <= '0;
            idx_q      <= '0;
            pen_q      <= 1'b0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            txint_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            thr_full_q <= thr_full_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            pen_q      <= pen_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            txint_q    <= txint_d;
        end
    end

    assign txd   = txd_q;
    assign tbe   = ~thr_full_q;
    assign tsre  = (state_q == ST_IDLE);
    assign txint = txint_q;

endmodule
